// File: rtl/sfifo_fwft_ctrl.sv
// sfifo_fwft_ctrl
// Single-clock FIFO controller around an external dual-port synchronous SRAM
// (1-cycle registered read data). The input and output sides are ready/valid
// streams. On the output side the head word is presented as soon as it is
// available (first-word-fall-through). A 2-entry output buffer (head + skid)
// hides the SRAM read latency, so the FIFO can move one word per cycle.
//
// Occupancy is tracked across three places:
//   SRAM      : wp - rp (pointers carry one extra MSB to tell full from empty)
//   in flight : a read was issued last cycle and its data returns this cycle
//   buffer    : 0..2 words held in head/skid
// Reads are only issued when the buffer is guaranteed to have room for the
// returning word. This gives total capacity Depth + 2.
module sfifo_fwft_ctrl #(
  parameter  int Width     = 8,
  parameter  int Depth     = 512,
  localparam int AddrLines = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rstn,
  // write-side stream
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [Width-1:0]     InData,
  // read-side stream
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [Width-1:0]     OutData,
  // SRAM write port
  output logic                 MemWRen,
  output logic [AddrLines-1:0] MemWRaddr,
  output logic [Width-1:0]     MemWRdata,
  // SRAM read port
  output logic                 MemRDen,
  output logic [AddrLines-1:0] MemRDaddr,
  input  logic [Width-1:0]     MemRDdata,
  // occupancy
  output logic [AddrLines:0]   Count
);

  localparam logic [AddrLines:0] DepthVal = (AddrLines + 1)'(Depth);

  // Registered state
  logic [AddrLines:0] wp_q, wp_d;
  logic [AddrLines:0] rp_q, rp_d;
  logic               inflight_q, inflight_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [Width-1:0]   head_q, head_d;
  logic [Width-1:0]   skid_q, skid_d;

  // Derived combinational signals
  logic [AddrLines:0] scnt;
  logic               push;
  logic               pop;
  logic               rden;
  logic [2:0]         slots_avail;
  logic [2:0]         slots_used;

  // Occupancy, handshakes and read-issue decision
  always_comb begin
    scnt = wp_q - rp_q;

    InReady  = (scnt != DepthVal);
    push     = InValid & InReady;

    OutValid = (bcnt_q != 2'd0);
    pop      = OutValid & OutReady;

    // A read may go out when it has credit, that is when
    // 2 - bcnt - inflight + pop > 0.
    // The comparison is done on unsigned terms so no value goes negative.
    slots_avail = 3'd2 + {2'b00, pop};
    slots_used  = {1'b0, bcnt_q} + {2'b00, inflight_q};
    rden        = (scnt != '0) && (slots_avail > slots_used);

    MemWRen   = push;
    MemWRaddr = wp_q[AddrLines-1:0];
    MemWRdata = InData;

    MemRDen   = rden;
    MemRDaddr = rp_q[AddrLines-1:0];

    OutData = head_q;

    Count = scnt
          + {{AddrLines{1'b0}}, inflight_q}
          + {{(AddrLines-1){1'b0}}, bcnt_q};
  end

  // Next-state for pointers and the in-flight read marker
  always_comb begin
    wp_d       = wp_q + {{AddrLines{1'b0}}, push};
    rp_d       = rp_q + {{AddrLines{1'b0}}, rden};
    inflight_d = rden;
  end

  // Output buffer update.
  // A pop shifts the skid entry into head first. Returning read data then
  // lands in the first free slot, which keeps words in order.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    bcnt_d = bcnt_q;
    if (pop) begin
      head_d = skid_q;
      bcnt_d = bcnt_q - 2'd1;
    end
    if (inflight_q) begin
      if (bcnt_d == 2'd0) begin
        head_d = MemRDdata;
      end else begin
        skid_d = MemRDdata;
      end
      bcnt_d = bcnt_d + 2'd1;
    end
  end

  // State registers; reset drops any read still in flight so that stale
  // MemRDdata returning after release is never captured
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q       <= '0;
      rp_q       <= '0;
      inflight_q <= 1'b0;
      bcnt_q     <= 2'd0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      inflight_q <= inflight_d;
      bcnt_q     <= bcnt_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: tb/tb_sfifo_fwft_ctrl.sv
// Testbench for sfifo_fwft_ctrl (Depth = 4).
// The bench holds a behavioural SRAM and a reference model. The model tracks
// where every word is: queued in the SRAM, in flight, or in the output
// buffer. All outputs are compared against the model once per cycle.
module tb_sfifo_fwft_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk;
  logic             rstn;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InData;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] OutData;
  logic             MemWRen;
  logic [AW-1:0]    MemWRaddr;
  logic [WIDTH-1:0] MemWRdata;
  logic             MemRDen;
  logic [AW-1:0]    MemRDaddr;
  logic [WIDTH-1:0] MemRDdata;
  logic [AW:0]      Count;

  sfifo_fwft_ctrl #(.Width(WIDTH), .Depth(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .InValid  (InValid),
    .InReady  (InReady),
    .InData   (InData),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutData  (OutData),
    .MemWRen  (MemWRen),
    .MemWRaddr(MemWRaddr),
    .MemWRdata(MemWRdata),
    .MemRDen  (MemRDen),
    .MemRDaddr(MemRDaddr),
    .MemRDdata(MemRDdata),
    .Count    (Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: synchronous write, registered read
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (MemWRen) mem[MemWRaddr] <= MemWRdata;
    if (MemRDen) MemRDdata <= mem[MemRDaddr];
  end

  // Reference model state
  logic [WIDTH-1:0] m_sram[$];
  logic [WIDTH-1:0] m_buf[$];
  bit               m_infl;
  logic [WIDTH-1:0] m_infl_data;
  int               m_wp, m_rp;
  bit               prev_stall;
  logic [WIDTH-1:0] prev_data;

  int n_tests = 0;
  int n_fail  = 0;
  int rden_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sram.delete();
    m_buf.delete();
    m_infl      = 1'b0;
    m_infl_data = '0;
    m_wp        = 0;
    m_rp        = 0;
    prev_stall  = 1'b0;
  endtask

  // One clock cycle. The inputs are driven, the outputs are compared at the
  // negedge, and the model advances at the posedge.
  task automatic step(input logic inv, input logic [WIDTH-1:0] ind, input logic ordy,
                      output logic pushed, output logic popped, output logic [WIDTH-1:0] pdata);
    logic e_ir, e_ov, e_rden, e_wr, e_pop;
    logic [WIDTH-1:0] e_od;
    int e_cnt;
    InValid  = inv;
    InData   = ind;
    OutReady = ordy;
    @(negedge clk);
    e_ir   = (m_sram.size() != DEPTH);
    e_ov   = (m_buf.size() != 0);
    e_od   = e_ov ? m_buf[0] : '0;
    e_cnt  = m_sram.size() + int'(m_infl) + m_buf.size();
    e_pop  = e_ov & ordy;
    e_rden = (m_sram.size() != 0) && ((m_buf.size() + int'(m_infl) - int'(e_pop)) < 2);
    e_wr   = inv & e_ir;
    check("inready", InReady, e_ir);
    check("outvalid", OutValid, e_ov);
    if (e_ov) check("outdata", OutData, e_od);
    check("count", Count, e_cnt);
    check("memrden", MemRDen, e_rden);
    if (e_rden) check("rdaddr", MemRDaddr, m_rp % DEPTH);
    check("memwren", MemWRen, e_wr);
    if (e_wr) begin
      check("wraddr", MemWRaddr, m_wp % DEPTH);
      check("wrdata", MemWRdata, ind);
    end
    if (prev_stall) check("stable", OutData, prev_data);
    prev_stall = e_ov & !ordy;
    prev_data  = e_od;
    if (MemRDen) rden_cnt++;
    @(posedge clk);
    if (e_pop) void'(m_buf.pop_front());
    if (m_infl) m_buf.push_back(m_infl_data);
    m_infl = e_rden;
    if (e_rden) begin
      m_infl_data = m_sram.pop_front();
      m_rp++;
    end
    if (e_wr) begin
      m_sram.push_back(ind);
      m_wp++;
    end
    #1;
    pushed = e_wr;
    popped = e_pop;
    pdata  = e_od;
  endtask

  initial begin
    logic ps, pp;
    logic [WIDTH-1:0] pd;
    int acc, exp_out, next_in, maxc;
    logic [WIDTH-1:0] sb[$];
    bit seen;

    rstn = 1'b0; InValid = 1'b0; InData = '0; OutReady = 1'b0;
    model_reset();
    rden_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", Count, 0);
    check("rst_inready", InReady, 1);
    check("rst_outvalid", OutValid, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, ps, pp, pd);

    // 2: single word, latency through the buffer
    step(1'b1, 8'hA5, 1'b0, ps, pp, pd);
    check("t2_pushed", ps, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, ps, pp, pd);
    check("t2_head", OutData, 8'hA5);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, ps, pp, pd);

    // 3: fill to capacity Depth+2 with the consumer stalled
    acc = 0; rden_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(i + 1), 1'b0, ps, pp, pd);
      if (ps) acc++;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, ps, pp, pd);
    check("t3_accepted", acc, 6);
    check("t3_rden_pulses", rden_cnt, 2);
    check("t3_count", Count, 6);
    check("t3_inready", InReady, 0);
    check("t3_head", OutData, 8'h01);
    exp_out = 1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 8'h00, 1'b1, ps, pp, pd);
      if (pp) begin check("t3_order", pd, exp_out); exp_out++; end
    end
    check("t3_drained", exp_out, 7);

    // 4: streaming at full rate, with several pointer wraps
    next_in = 0; exp_out = 0; maxc = 0;
    for (int cyc = 0; cyc < 200 && exp_out < 40; cyc++) begin
      step(next_in < 40, 8'(next_in), 1'b1, ps, pp, pd);
      if (int'(Count) > maxc) maxc = int'(Count);
      if (ps) next_in++;
      if (pp) begin check("t4_order", pd, exp_out); exp_out++; end
    end
    check("t4_all_out", exp_out, 40);
    check("t4_max_count_le3", (maxc <= 3), 1);

    // 5: random traffic with a scoreboard
    sb.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int bias;
      logic iv, orr;
      logic [WIDTH-1:0] d;
      bias = (cyc / 500) % 4;
      iv  = ($urandom_range(0, 3) >= bias[1:0] / 2);
      orr = ($urandom_range(0, 3) >= (3 - bias) / 2);
      d   = 8'($urandom);
      step(iv, d, orr, ps, pp, pd);
      if (ps) sb.push_back(d);
      if (pp) begin
        if (sb.size() == 0) check("t5_underflow", 1, 0);
        else check("t5_data", pd, sb.pop_front());
      end
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      step(1'b0, 8'h00, 1'b1, ps, pp, pd);
      if (pp) check("t5_drain", pd, sb.pop_front());
    end
    check("t5_sb_empty", sb.size(), 0);

    // 6: reset during a cycle with a read issued and the buffer full
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, ps, pp, pd);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, ps, pp, pd);
    InValid = 1'b0; OutReady = 1'b1;
    @(negedge clk);
    check("t6_pre_rden", MemRDen, 1);
    check("t6_pre_bcnt2", (m_buf.size() == 2), 1);
    check("t6_pre_outvalid", OutValid, 1);
    rstn = 1'b0;
    #1;
    check("t6_rst_outvalid", OutValid, 0);
    check("t6_rst_outdata", OutData, 0);
    check("t6_rst_count", Count, 0);
    check("t6_rst_rden", MemRDen, 0);
    check("t6_rst_wren", MemWRen, 0);
    check("t6_rst_inready", InReady, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    @(posedge clk); #1;
    step(1'b1, 8'h3C, 1'b0, ps, pp, pd);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b0, 8'h00, 1'b1, ps, pp, pd);
      if (pp) begin check("t6_first_out", pd, 8'h3C); seen = 1'b1; end
    end
    check("t6_seen", seen, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sfifo_fwft_ctrl.md
Name: sfifo_fwft_ctrl

Overview:
- Single-clock FIFO controller that drives an external dual-port synchronous SRAM: write port, read port, and 1-cycle registered read data.
- Presents ready/valid streams on input and output, with first-word-fall-through on the output side.
- Hides SRAM read latency with a 2-entry output buffer, giving full throughput of one word per cycle.
- Pairs with the team's SRAM macro: both SRAM clocks are tied to clk.

Parameters:
- Width, 8, data word width in bits.
- Depth, 512, SRAM word count; must be a power of two, >= 4. AddrLines = clog2(Depth).

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- InValid  in  1  input word offered
- InReady  out  1  controller can accept a word
- InData  in  Width  input word
- OutValid  out  1  OutData holds valid head word
- OutReady  in  1  consumer takes head word
- OutData  out  Width  head-of-FIFO word
- MemWRen  out  1  SRAM write enable
- MemWRaddr  out  AddrLines  SRAM write address
- MemWRdata  out  Width  SRAM write data
- MemRDen  out  1  SRAM read enable
- MemRDaddr  out  AddrLines  SRAM read address
- MemRDdata  in  Width  SRAM read data, valid the cycle after MemRDen
- Count  out  AddrLines+1  total words held (SRAM + in-flight + buffer)

Behaviour:
- Reset, async on rstn low:
  - wp = rp = 0 (AddrLines+1 bits each); inflight = 0; buffer empty.
  - OutValid = 0, OutData = 0, Count = 0, MemWRen = 0, MemRDen = 0, InReady = 1.
- Reset mid-operation clears everything immediately. MemRDdata returned after reset release for a pre-reset read is ignored.
- SRAM occupancy: scnt = wp - rp, modulo 2^(AddrLines+1). SRAM full when scnt == Depth.
- Write side:
  - InReady = (scnt != Depth).
  - Push = InValid & InReady.
  - MemWRen = push; MemWRaddr = wp[AddrLines-1:0]; MemWRdata = InData; wp increments on push.
- Output buffer: 2 entries, head and skid, with bcnt 0..2. OutValid = (bcnt != 0). OutData = head entry. Pop = OutValid & OutReady.
- Read issue:
  - credit = 2 - bcnt - inflight + pop.
  - MemRDen = (scnt != 0) & (credit > 0).
  - MemRDaddr = rp[AddrLines-1:0]; rp increments on MemRDen; inflight <= MemRDen.
- Data return: when inflight = 1, MemRDdata is written into the buffer at that edge.
  - If a pop happens in the same cycle, the entries shift first.
  - Order must be preserved: skid moves to head on pop, and new data goes to the first free slot.
- Simultaneous events:
  - Push and MemRDen in the same cycle are allowed.
  - A read never targets the address being written, because scnt > 0 means the entry was written at an earlier edge.
  - Pop plus return in the same cycle keeps bcnt unchanged.
- Count = scnt + inflight + bcnt, registered-state derived. Maximum capacity is Depth + 2.
- Latency, push at edge 0 into an empty FIFO:
  - MemRDen high in cycle 1.
  - Data captured at edge 2.
  - OutValid high in cycle 3.
- Steady state with InValid = OutReady = 1: one word per cycle in and out.
- Wrap-around: pointers roll over naturally. The extra MSB distinguishes full from empty.
- OutData is held stable while OutValid & !OutReady.
- InData is ignored when InReady = 0.
- Count is combinational from registers. InReady, MemWRen, MemWRaddr, MemWRdata and MemRDen may be combinational, but must have no path from MemRDdata.

Test Plan:
1. Release rstn, idle 5 cycles -> InReady=1, OutValid=0, Count=0, MemWRen=MemRDen=0.
2. Push one word 0xA5 at cycle 0, OutReady=0 -> MemWRen at cycle 0 with addr 0; MemRDen at cycle 1 with addr 0; OutValid=1 with OutData=0xA5 from cycle 3; Count=1 throughout.
3. Depth=4, OutReady=0, offer 0x01..0x08 back-to-back -> exactly 6 accepted; InReady=0 after the 6th; Count=6; MemRDen pulsed exactly twice; OutData=0x01.
4. Depth=4, InValid=OutReady=1, 40 words 0x00..0x27 -> after 3-cycle fill, one output per cycle in order; multiple pointer wraps; Count never exceeds 3.
5. Random OutReady and InValid for 2000 cycles with a scoreboard -> no loss, duplication or reordering; OutData stable while stalled; Count matches the model every cycle.
6. Assert rstn during a cycle with MemRDen=1 and bcnt=2 -> outputs immediately at reset values; after release, stale MemRDdata is not loaded; the next push of 0x3C appears as the first output.
